// File: rtl/timer_mc_pkg.sv
// Shared constants and helpers for the multi-channel APB timer.
package timer_mc_pkg;

    // Per-channel register offsets (byte addresses inside a channel window)
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_CMP_LO = 5'h04;
    localparam logic [4:0] OFF_CMP_HI = 5'h08;
    localparam logic [4:0] OFF_CNT_LO = 5'h0C;
    localparam logic [4:0] OFF_CNT_HI = 5'h10;
    localparam logic [4:0] OFF_INT_EN = 5'h14;
    localparam logic [4:0] OFF_INT_ST = 5'h18;
    localparam logic [4:0] OFF_STAT   = 5'h1C;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_RELOAD   = 1;
    localparam int CTRL_ONESHOT  = 2;
    localparam int CTRL_HALT_REQ = 3;
    localparam int CTRL_DIV_EN   = 4;
    localparam int CTRL_DIV_VAL  = 8;

    // Address distance between consecutive channels
    localparam int CH_STRIDE = 32'h20;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_WAIT,
        APB_DONE
    } apb_state_e;

    // Merge a 32-bit write into an existing word, byte lane by byte lane.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_mc_ch.sv
// One timer channel: control/compare/counter/interrupt registers, prescaler,
// debug halt, counter step and match detection.
module timer_mc_ch
    import timer_mc_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_mode,
    input  logic        wr_en,
    input  logic [4:0]  offset,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        halt_ack
);
    localparam int HI_W   = CNT_W - 32;
    localparam int DIV_CW = 1 << DIV_W;

    logic              en, reload, oneshot, halt_req, div_en;
    logic [DIV_W-1:0]  div_val;
    logic [CNT_W-1:0]  cmp, cnt, cnt_step;
    logic [DIV_CW-1:0] div_cnt, div_term;
    logic              int_en, int_st;
    logic              halted, cnt_en, tick, match, oneshot_clr, div_change;
    logic              wr_ctrl, wr_cmp_lo, wr_cmp_hi, wr_cnt_lo, wr_cnt_hi, wr_int_en, wr_int_st;
    logic [31:0]       ctrl_rd, ctrl_base, ctrl_new;
    logic [31:0]       cmp_hi_rd, cnt_hi_rd;
    logic [31:0]       cmp_lo_new, cmp_hi_new, cnt_lo_new, cnt_hi_new;
    logic              unused_ok;

    assign wr_ctrl   = wr_en && (offset == OFF_CTRL);
    assign wr_cmp_lo = wr_en && (offset == OFF_CMP_LO);
    assign wr_cmp_hi = wr_en && (offset == OFF_CMP_HI);
    assign wr_cnt_lo = wr_en && (offset == OFF_CNT_LO);
    assign wr_cnt_hi = wr_en && (offset == OFF_CNT_HI);
    assign wr_int_en = wr_en && (offset == OFF_INT_EN);
    assign wr_int_st = wr_en && (offset == OFF_INT_ST);

    assign cmp_hi_rd = 32'(cmp[CNT_W-1:32]);
    assign cnt_hi_rd = 32'(cnt[CNT_W-1:32]);

    // Assemble the CTRL image; the base used for writes already reflects a one-shot stop
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ctrl_rd                          = '0;
        ctrl_rd[CTRL_EN]                 = en;
        ctrl_rd[CTRL_RELOAD]             = reload;
        ctrl_rd[CTRL_ONESHOT]            = oneshot;
        ctrl_rd[CTRL_HALT_REQ]           = halt_req;
        ctrl_rd[CTRL_DIV_EN]             = div_en;
        ctrl_rd[CTRL_DIV_VAL +: DIV_W]   = div_val;
        ctrl_base                        = ctrl_rd;
        ctrl_base[CTRL_EN]               = en & ~oneshot_clr;
    end

    assign ctrl_new   = apply_strb(ctrl_base, wdata, strb);
    assign cmp_lo_new = apply_strb(cmp[31:0], wdata, strb);
    assign cmp_hi_new = apply_strb(cmp_hi_rd, wdata, strb);
    assign cnt_lo_new = apply_strb(cnt[31:0], wdata, strb);
    assign cnt_hi_new = apply_strb(cnt_hi_rd, wdata, strb);

    assign div_change = wr_ctrl && ((ctrl_new[CTRL_DIV_EN] != div_en) ||
                                    (ctrl_new[CTRL_DIV_VAL +: DIV_W] != div_val));

    assign halted      = dbg_mode & halt_req;
    assign cnt_en      = en & ~halted;
    assign div_term    = (DIV_CW'(1) << div_val) - DIV_CW'(1);
    assign tick        = cnt_en & (~div_en | (div_cnt == div_term));
    // Reload to 0 only matches when cmp is 0, which the equality below covers as well
    assign cnt_step    = (reload && (cnt == cmp)) ? '0 : cnt + CNT_W'(1);
    assign match       = tick & ~wr_cnt_lo & ~wr_cnt_hi & (cnt_step == cmp);
    assign oneshot_clr = match & oneshot;

    // CTRL register; an APB write overrides the one-shot stop
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            oneshot  <= 1'b0;
            halt_req <= 1'b0;
            div_en   <= 1'b0;
            div_val  <= '0;
        end else if (wr_ctrl) begin
            en       <= ctrl_new[CTRL_EN];
            reload   <= ctrl_new[CTRL_RELOAD];
            oneshot  <= ctrl_new[CTRL_ONESHOT];
            halt_req <= ctrl_new[CTRL_HALT_REQ];
            div_en   <= ctrl_new[CTRL_DIV_EN];
            div_val  <= ctrl_new[CTRL_DIV_VAL +: DIV_W];
        end else begin
            en       <= ctrl_base[CTRL_EN];
        end
    end

    // Compare register, byte-writable in two halves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp <= '0;
        end else begin
            if (wr_cmp_lo) cmp[31:0]       <= cmp_lo_new;
            if (wr_cmp_hi) cmp[CNT_W-1:32] <= cmp_hi_new[HI_W-1:0];
        end
    end

    // Prescaler: counts 0..2^div_val-1, restarts when stopped, halted or reprogrammed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!cnt_en || !div_en || div_change || (div_cnt == div_term)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_CW'(1);
        end
    end

    // Counter; software writes take precedence over a tick in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_cnt_lo || wr_cnt_hi) begin
            if (wr_cnt_lo) cnt[31:0]       <= cnt_lo_new;
            if (wr_cnt_hi) cnt[CNT_W-1:32] <= cnt_hi_new[HI_W-1:0];
        end else if (tick) begin
            cnt <= cnt_step;
        end
    end

    // Interrupt enable/status and registered halt acknowledge; a match beats W1C
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_en   <= 1'b0;
            int_st   <= 1'b0;
            halt_ack <= 1'b0;
        end else begin
            if (wr_int_en && strb[0]) int_en <= wdata[0];
            if (match) begin
                int_st <= 1'b1;
            end else if (wr_int_st && strb[0] && wdata[0]) begin
                int_st <= 1'b0;
            end
            halt_ack <= halted & en;
        end
    end

    // Register read mux; reserved bits and offsets read 0
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:   rdata = ctrl_rd;
            OFF_CMP_LO: rdata = cmp[31:0];
            OFF_CMP_HI: rdata = cmp_hi_rd;
            OFF_CNT_LO: rdata = cnt[31:0];
            OFF_CNT_HI: rdata = cnt_hi_rd;
            OFF_INT_EN: rdata = {31'b0, int_en};
            OFF_INT_ST: rdata = {31'b0, int_st};
            OFF_STAT:   rdata = {31'b0, halt_ack};
            default:    rdata = '0;
        endcase
    end

    assign irq       = int_en & int_st;
    assign unused_ok = ^{ctrl_new, cmp_hi_new, cnt_hi_new};

endmodule

// File: rtl/timer_mc_apb.sv
// Multi-channel APB timer: one-wait-state APB slave, address decode, read mux,
// error response and NUM_CH timer channels with a combined interrupt.
module timer_mc_apb
    import timer_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int DIV_W  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              dbg_mode,
    input  logic [11:0]       tim_paddr,
    input  logic              tim_psel,
    input  logic              tim_penable,
    input  logic              tim_pwrite,
    input  logic [31:0]       tim_pwdata,
    input  logic [3:0]        tim_pstrb,
    output logic [31:0]       tim_prdata,
    output logic              tim_pready,
    output logic              tim_pslverr,
    output logic [NUM_CH-1:0] tim_int_vec,
    output logic              tim_int
);
    apb_state_e        state, state_next;
    logic [2:0]        ch_idx;
    logic [4:0]        offset;
    logic              access_err, wr_commit, done;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       rd_mux;
    logic [NUM_CH-1:0] ch_irq, ch_halt_ack;
    logic              unused_ok;

    assign ch_idx = tim_paddr[7:5];
    assign offset = tim_paddr[4:0];

    // Out-of-range, unaligned and read-only-register writes all complete with an error
    assign access_err = (tim_paddr >= 12'(NUM_CH * CH_STRIDE)) ||
                        (tim_paddr[1:0] != 2'b00) ||
                        (tim_pwrite && (offset == OFF_STAT));

    // APB state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= APB_IDLE;
        else         state <= state_next;
    end

    // APB next state: setup -> first access cycle (WAIT) -> completion (DONE)
    always_comb begin
        state_next = state;
        case (state)
            APB_IDLE: if (tim_psel) state_next = APB_WAIT;
            APB_WAIT: begin
                if (!tim_psel)                state_next = APB_IDLE;
                else if (tim_penable)         state_next = APB_DONE;
            end
            APB_DONE: state_next = APB_IDLE;
            default:  state_next = APB_IDLE;
        endcase
    end

    assign done        = (state == APB_DONE) && tim_psel && tim_penable;
    assign wr_commit   = done && tim_pwrite && !access_err;
    assign tim_pready  = (state == APB_DONE);
    assign tim_pslverr = done && access_err;
    assign tim_prdata  = (done && !tim_pwrite && !access_err) ? rd_mux : 32'h0;

    // Select the addressed channel's read data
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 3'(c)) rd_mux = ch_rdata[c];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        timer_mc_ch #(
            .CNT_W (CNT_W),
            .DIV_W (DIV_W)
        ) u_ch (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .dbg_mode (dbg_mode),
            .wr_en    (wr_commit && (ch_idx == 3'(c))),
            .offset   (offset),
            .wdata    (tim_pwdata),
            .strb     (tim_pstrb),
            .rdata    (ch_rdata[c]),
            .irq      (ch_irq[c]),
            .halt_ack (ch_halt_ack[c])
        );
    end

    assign tim_int_vec = ch_irq;
    assign tim_int     = |ch_irq;
    assign unused_ok   = ^ch_halt_ack;

endmodule

// File: tb/tb_timer_mc_apb.sv
// Scoreboard bench for timer_mc_apb: the driver queues expected APB responses,
// a monitor compares them whenever pready is seen.
module tb_timer_mc_apb;
    localparam int NUM_CH = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              dbg_mode = 1'b0;
    logic [11:0]       tim_paddr = '0;
    logic              tim_psel = 1'b0;
    logic              tim_penable = 1'b0;
    logic              tim_pwrite = 1'b0;
    logic [31:0]       tim_pwdata = '0;
    logic [3:0]        tim_pstrb = '0;
    logic [31:0]       tim_prdata;
    logic              tim_pready;
    logic              tim_pslverr;
    logic [NUM_CH-1:0] tim_int_vec;
    logic              tim_int;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    timer_mc_apb #(.NUM_CH(NUM_CH), .CNT_W(64), .DIV_W(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .dbg_mode    (dbg_mode),
        .tim_paddr   (tim_paddr),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr),
        .tim_int_vec (tim_int_vec),
        .tim_int     (tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pops one expectation
    always @(negedge sys_clk) begin
        exp_t e;
        if (tim_pready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pready: got pready=1 expected no transfer");
            end else begin
                e = sb.pop_front();
                check({e.name, " prdata"}, tim_prdata, e.rdata);
                check({e.name, " pslverr"}, {31'b0, tim_pslverr}, {31'b0, e.err});
            end
        end
    end

    // One APB transfer; called just after edge X, write commits at X+4, returns at X+4.5
    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                       input string name);
        exp_t e;
        int   n;
        e.rdata = wr ? 32'h0 : exp_rd;
        e.err   = exp_err;
        e.name  = name;
        sb.push_back(e);
        @(posedge sys_clk); #1;
        tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = wr;
        tim_paddr = addr; tim_pwdata = data; tim_pstrb = strb;
        @(posedge sys_clk); #1;
        tim_penable = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!tim_pready && n < 8);
        check({name, " pready_cycle"}, n, 2);
        @(posedge sys_clk); #1;
        tim_psel = 1'b0; tim_penable = 1'b0; tim_pwrite = 1'b0;
        @(negedge sys_clk);
        check({name, " pready_drop"}, {31'b0, tim_pready}, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input string name);
        apb(1'b1, a, d, 4'hF, 32'h0, 1'b0, name);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        apb(1'b0, a, 32'h0, 4'hF, exp, 1'b0, name);
    endtask

    task automatic reset_dut();
        @(negedge sys_clk);
        sys_rst = 1'b1; dbg_mode = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic step_check_int(input int ch, input logic exp, input string name);
        @(posedge sys_clk); #1;
        check(name, {31'b0, tim_int_vec[ch]}, {31'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst prdata", tim_prdata, 0);
        check("rst pready", {31'b0, tim_pready}, 0);
        check("rst int_vec", {28'b0, tim_int_vec}, 0);
        sys_rst = 1'b0;
        #1;
        check("post_rst pslverr", {31'b0, tim_pslverr}, 0);
        check("post_rst int", {31'b0, tim_int}, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            rd(12'(c * 32 + 'h00), 0, $sformatf("rst ch%0d ctrl", c));
            rd(12'(c * 32 + 'h0C), 0, $sformatf("rst ch%0d cnt_lo", c));
            rd(12'(c * 32 + 'h18), 0, $sformatf("rst ch%0d int_st", c));
        end

        // Ch0 free-run: match when CNT becomes 5 (enable edge E, CNT=k after E+k)
        wr(12'h004, 5, "ch0 cmp");
        wr(12'h014, 1, "ch0 int_en");
        wr(12'h000, 1, "ch0 ctrl");
        for (int k = 1; k <= 4; k++) step_check_int(0, 1'b0, "ch0 no_irq_before_match");
        step_check_int(0, 1'b1, "ch0 irq_at_match");
        check("ch0 tim_int", {31'b0, tim_int}, 1);
        rd(12'h00C, 8, "ch0 cnt_keeps_counting");
        wr(12'h018, 1, "ch0 w1c");
        check("ch0 int_cleared", {31'b0, tim_int}, 0);
        rd(12'h018, 0, "ch0 int_st_after_w1c");

        // Ch1 auto-reload with CMP=3: period 4, match at E+3, E+7, ...
        reset_dut();
        wr(12'h024, 3, "ch1 cmp");
        wr(12'h034, 1, "ch1 int_en");
        wr(12'h020, 3, "ch1 ctrl");
        step_check_int(1, 1'b0, "ch1 e1");
        step_check_int(1, 1'b0, "ch1 e2");
        step_check_int(1, 1'b1, "ch1 e3_match");
        rd(12'h02C, 2, "ch1 cnt_e6");
        wr(12'h038, 1, "ch1 w1c_with_match");
        check("ch1 match_beats_w1c", {31'b0, tim_int_vec[1]}, 1);
        @(posedge sys_clk); #1;
        wr(12'h038, 1, "ch1 w1c");
        check("ch1 cleared", {31'b0, tim_int_vec[1]}, 0);
        step_check_int(1, 1'b0, "ch1 e17");
        step_check_int(1, 1'b0, "ch1 e18");
        step_check_int(1, 1'b1, "ch1 e19_rematch");
        @(posedge sys_clk); #1;
        rd(12'h02C, 3, "ch1 cnt_e23");
        @(posedge sys_clk); #1;
        rd(12'h02C, 0, "ch1 cnt_e28_reloaded");

        // Ch2 one-shot: holds at CMP and clears en
        reset_dut();
        wr(12'h044, 3, "ch2 cmp");
        wr(12'h040, 5, "ch2 ctrl");
        rd(12'h040, 4, "ch2 ctrl_en_cleared");
        rd(12'h04C, 3, "ch2 cnt_held");
        rd(12'h058, 1, "ch2 int_st");
        check("ch2 irq_masked", {31'b0, tim_int_vec[2]}, 0);

        // Ch3 prescaled by 4, then 64-bit wrap
        reset_dut();
        wr(12'h060, 32'h211, "ch3 ctrl_div");
        rd(12'h06C, 0, "ch3 cnt_e3");
        rd(12'h06C, 1, "ch3 cnt_e7");
        rd(12'h06C, 2, "ch3 cnt_e11");
        wr(12'h060, 32'h210, "ch3 stop");
        wr(12'h06C, 32'hFFFF_FFFF, "ch3 cnt_lo_ones");
        wr(12'h070, 32'hFFFF_FFFF, "ch3 cnt_hi_ones");
        wr(12'h060, 32'h211, "ch3 restart");
        rd(12'h070, 32'hFFFF_FFFF, "ch3 hi_before_wrap");
        rd(12'h06C, 0, "ch3 lo_wrapped");
        rd(12'h070, 0, "ch3 hi_wrapped");

        // Debug halt on ch0
        reset_dut();
        wr(12'h000, 32'h9, "halt ctrl");
        @(posedge sys_clk); #1;
        dbg_mode = 1'b1;
        rd(12'h01C, 1, "halt stat_ack");
        rd(12'h00C, 1, "halt cnt_frozen");
        @(posedge sys_clk);
        @(posedge sys_clk); #1;
        dbg_mode = 1'b0;
        rd(12'h00C, 4, "halt cnt_resumed");
        rd(12'h01C, 0, "halt stat_released");

        // Error responses, boundaries and byte strobes
        reset_dut();
        wr(12'h004, 32'h1234_5678, "err cmp_setup");
        apb(1'b0, 12'h080, 0, 4'hF, 0, 1'b1, "err rd_out_of_range");
        apb(1'b1, 12'h080, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, "err wr_out_of_range");
        apb(1'b1, 12'h002, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, "err wr_unaligned_2");
        apb(1'b1, 12'h005, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, "err wr_unaligned_5");
        apb(1'b1, 12'h01C, 32'h1, 4'hF, 0, 1'b1, "err wr_stat");
        apb(1'b0, 12'h0FC, 0, 4'hF, 0, 1'b1, "err rd_far");
        rd(12'h004, 32'h1234_5678, "err cmp_unchanged");
        rd(12'h07C, 0, "err last_valid_addr");
        rd(12'h01C, 0, "err stat_read_ok");
        apb(1'b1, 12'h008, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, "strb cmp_hi");
        rd(12'h008, 32'h00BB_00DD, "strb cmp_hi_readback");

        // Asynchronous reset during the completion cycle of a read
        reset_dut();
        wr(12'h004, 2, "mid cmp");
        wr(12'h014, 1, "mid int_en");
        wr(12'h000, 1, "mid ctrl");
        repeat (3) @(posedge sys_clk);
        #1;
        check("mid int_before_reset", {31'b0, tim_int}, 1);
        @(posedge sys_clk); #1;
        tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = 1'b0; tim_paddr = 12'h004; tim_pstrb = 4'hF;
        @(posedge sys_clk); #1;
        tim_penable = 1'b1;
        @(posedge sys_clk); #1;
        check("mid pready_before_reset", {31'b0, tim_pready}, 1);
        sys_rst = 1'b1;
        #1;
        check("mid pready", {31'b0, tim_pready}, 0);
        check("mid prdata", tim_prdata, 0);
        check("mid pslverr", {31'b0, tim_pslverr}, 0);
        check("mid int_vec", {28'b0, tim_int_vec}, 0);
        check("mid int", {31'b0, tim_int}, 0);
        tim_psel = 1'b0; tim_penable = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        rd(12'h004, 0, "mid cmp_after_reset");

        repeat (2) @(posedge sys_clk);
        check("scoreboard drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_mc_apb.md
Name: timer_mc_apb

Overview:
- Parametrised multi-channel successor of the single 64-bit APB timer.
- NUM_CH independent timer channels; each has its own counter, prescaler, compare register, one-shot/auto-reload mode, debug halt and interrupt.
- Sits on the peripheral APB bus.
- Drives a per-channel interrupt vector plus one combined interrupt to the interrupt controller.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- CNT_W, 64, counter/compare width (33..64); HI registers expose bits [CNT_W-1:32], upper bits read 0.
- DIV_W, 4, prescaler select width; tick period is 2^div_val cycles.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- dbg_mode  in  1  debug-mode indication from the CPU.
- tim_paddr  in  12  APB address.
- tim_psel  in  1  APB select.
- tim_penable  in  1  APB enable.
- tim_pwrite  in  1  APB write.
- tim_pwdata  in  32  APB write data.
- tim_pstrb  in  4  APB byte strobes.
- tim_prdata  out  32  APB read data.
- tim_pready  out  1  APB ready.
- tim_pslverr  out  1  APB error.
- tim_int_vec  out  NUM_CH  per-channel interrupt (int_en & int_st).
- tim_int  out  1  OR-reduction of tim_int_vec.

Behaviour:
- Reset: every register and divider is 0; tim_prdata=0, tim_pready=0, tim_pslverr=0, tim_int_vec=0, tim_int=0.
- APB handshake:
  - One wait state. In the first access cycle (psel&penable) pready=0; in the second, pready=1, and the write commits or prdata is valid.
  - pready is registered and drops the cycle after completion.
  - prdata is 0 except on the read completion cycle.
- Register map, channel c at base c*0x20:
  - 0x00 CTRL: [0] en, [1] reload, [2] oneshot, [3] halt_req, [4] div_en, [8+:DIV_W] div_val.
  - 0x04 CMP_LO, 0x08 CMP_HI.
  - 0x0C CNT_LO, 0x10 CNT_HI.
  - 0x14 INT_EN[0].
  - 0x18 INT_ST[0], write-1-to-clear.
  - 0x1C STAT[0] halt_ack, read-only.
- Writes honour pstrb per byte. Reserved bits read 0.
- pslverr=1 on the completion cycle, with no state change, for:
  - address >= NUM_CH*0x20;
  - unaligned address (paddr[1:0]!=0);
  - write to STAT.
- Tick:
  - div_en=0: tick every cycle while cnt_en.
  - div_en=1: divider counts 0..2^div_val-1 and ticks on terminal count.
  - The divider clears when en=0, when halted, or on any write to CTRL that changes div_val or div_en.
- cnt_en = en & ~(dbg_mode & halt_req). halt_ack = dbg_mode & halt_req & en, registered (1 cycle latency).
- Counter step on a tick:
  - If reload=1 and cnt==cmp: cnt <= 0.
  - Otherwise cnt <= cnt+1, wrapping from all-ones to 0.
- Match:
  - Set int_st in the same edge the counter is loaded with a value equal to cmp (cnt_next==cmp with a tick). Exception: reload-to-0 sets int_st only if cmp==0.
  - If oneshot=1, en clears on the same edge (counter holds at cmp).
- Priority, same cycle:
  - APB write to CNT_LO/HI beats tick; the written bytes load and the other bytes hold.
  - Match set beats INT_ST W1C.
  - APB write to CTRL.en=1 beats oneshot clear.
- No match is generated by an APB write to CNT or CMP itself.
- tim_int_vec[c] is combinational from registered int_en & int_st. tim_int is the OR of all bits.
- Asynchronous reset mid-transfer aborts it: pready=0 and no state change.

Decomposition:
- Package timer_mc_pkg holds:
  - register offset constants (CTRL, CMP_LO, CMP_HI, CNT_LO, CNT_HI, INT_EN, INT_ST, STAT);
  - CTRL bit-position constants;
  - channel stride 0x20.
- Sub-module timer_mc_ch, instantiated NUM_CH times, contains:
  - CTRL/CMP/CNT/INT registers;
  - divider, halt logic, counter and match logic.
  - Its inputs are a decoded per-channel write strobe, offset, data and strb; its outputs are read data, irq and halt_ack.
- The top holds the APB FSM (IDLE -> WAIT -> DONE -> IDLE), address decode, read mux and error generation.

Test Plan:
- Reset, then read every channel's CTRL/CNT/INT_ST -> all 0; pslverr=0; pready high for exactly one cycle per access, in the second penable cycle.
- Ch0: CMP=5, INT_EN=1, CTRL=0x1 (free-run) -> tim_int_vec[0]=1 on the edge where CNT becomes 5; CNT keeps counting; W1C 0x1 to INT_ST -> tim_int=0.
- Ch1: CMP=3, CTRL=reload|en -> CNT sequence 0,1,2,3,0,1... with int_st set once per period. Ch2: CTRL=oneshot|en, CMP=3 -> CNT holds 3, CTRL.en reads 0.
- Ch3: div_en=1, div_val=2 -> CNT increments every 4 cycles. Write CNT_LO=0xFFFFFFFF, CNT_HI=0xFFFFFFFF -> next tick wraps to 0.
- halt_req=1 with dbg_mode toggled 1 for 10 cycles -> CNT frozen, STAT=1 a cycle later; resumes from the same value on dbg_mode=0.
- Invalid address 0x80 (NUM_CH=4), unaligned 0x002, write to STAT -> pslverr=1, registers unchanged. Same-cycle W1C and match -> INT_ST stays 1. Assert sys_rst mid-transfer -> all outputs 0.
